memory_controller: RTL and testbench

Byte-serial RAM front end between the RAM port and two requesters: the load/store buffer and the instruction fetcher. It latches one-cycle request pulses, arbitrates between them with the LSB winning ties, and moves 1/2/4-byte little-endian transfers through an 8-bit RAM. It returns a one-cycle ready pulse with the assembled data. It also stalls writes to the IO region while the IO buffer is full, and drops speculative reads on ROB rollback.

---
 rtl/memory_controller_if.sv | 39 +++
 rtl/memory_controller.sv | 154 +++++++++++++++
 tb/tb_memory_controller.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_controller_if.sv
// Request/response and RAM-port bundle for the byte-serial memory controller.
// The controller takes the slave view; requesters and the RAM model take the master view.
interface memory_controller_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  if_request_in;
  logic [ADDR_WIDTH-1:0] if_address_in;
  logic                  if_ready_out;
  logic [31:0]           if_inst_out;
  logic                  lsb_request_in;
  logic                  lsb_rw_signal_in;
  logic [ADDR_WIDTH-1:0] lsb_address_in;
  logic [2:0]            lsb_goal_in;
  logic [31:0]           lsb_data_in;
  logic                  lsb_ready_out;
  logic [31:0]           lsb_data_out;
  logic                  rob_rollback_in;
  logic [7:0]            mem_din_in;
  logic [7:0]            mem_dout_out;
  logic [ADDR_WIDTH-1:0] mem_a_out;
  logic                  mem_wr_out;
  logic                  io_buffer_full_in;

  modport slave (
    input  if_request_in, if_address_in, lsb_request_in, lsb_rw_signal_in,
           lsb_address_in, lsb_goal_in, lsb_data_in, rob_rollback_in,
           mem_din_in, io_buffer_full_in,
    output if_ready_out, if_inst_out, lsb_ready_out, lsb_data_out,
           mem_dout_out, mem_a_out, mem_wr_out
  );

  modport master (
    output if_request_in, if_address_in, lsb_request_in, lsb_rw_signal_in,
           lsb_address_in, lsb_goal_in, lsb_data_in, rob_rollback_in,
           mem_din_in, io_buffer_full_in,
    input  if_ready_out, if_inst_out, lsb_ready_out, lsb_data_out,
           mem_dout_out, mem_a_out, mem_wr_out
  );
endinterface

// File: rtl/memory_controller.sv
// Byte-serial RAM front end: latches LSB/IF request pulses, LSB wins ties, and
// moves 1/2/4-byte little-endian transfers through the 8-bit RAM port.
module memory_controller #(
  parameter int         ADDR_WIDTH = 32,
  parameter logic [1:0] IO_REGION  = 2'b11
) (
  input logic               clk,
  input logic               rst,
  memory_controller_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;
  state_e state_q, state_d;

  logic [2:0]            k_q, n_q;
  logic                  own_lsb_q, full_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q, buf_q;
  logic                  if_pend_q, lsb_pend_q, lsb_rw_pend_q;
  logic [ADDR_WIDTH-1:0] if_addr_pend_q, lsb_addr_pend_q;
  logic [2:0]            lsb_goal_pend_q;
  logic [31:0]           lsb_data_pend_q;
  logic                  lsb_rdy_q, if_rdy_q;
  logic [31:0]           lsb_data_q, if_inst_q;

  function automatic logic [2:0] goal_n(input logic [2:0] g);
    case (g)
      3'd1:    return 3'd1;
      3'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Rollback kills new pulses and speculative (load/fetch) pending work.
  logic rb, lsb_new, if_new, lsb_vld, if_vld, acc_lsb, acc_if;
  assign rb      = bus.rob_rollback_in;
  assign lsb_new = bus.lsb_request_in && !rb;
  assign if_new  = bus.if_request_in && !rb;
  assign lsb_vld = (lsb_pend_q && (!rb || lsb_rw_pend_q)) || lsb_new;
  assign if_vld  = (if_pend_q && !rb) || if_new;
  assign acc_lsb = (state_q == IDLE) && lsb_vld;
  assign acc_if  = (state_q == IDLE) && !lsb_vld && if_vld;

  logic                  lsb_rw;
  logic [ADDR_WIDTH-1:0] lsb_addr, if_addr;
  logic [2:0]            lsb_goal;
  logic [31:0]           lsb_data;
  assign lsb_rw   = lsb_pend_q ? lsb_rw_pend_q   : bus.lsb_rw_signal_in;
  assign lsb_addr = lsb_pend_q ? lsb_addr_pend_q : bus.lsb_address_in;
  assign lsb_goal = lsb_pend_q ? lsb_goal_pend_q : bus.lsb_goal_in;
  assign lsb_data = lsb_pend_q ? lsb_data_pend_q : bus.lsb_data_in;
  assign if_addr  = if_pend_q  ? if_addr_pend_q  : bus.if_address_in;

  logic [ADDR_WIDTH-1:0] byte_addr;
  logic                  last_k, wr_go, rd_done;
  logic [1:0]            cap_idx;
  logic [31:0]           rd_word;
  assign byte_addr = addr_q + ADDR_WIDTH'(k_q);
  assign last_k    = (k_q == n_q - 3'd1);
  // full_q is last cycle's buffer state: a full buffer withholds the next IO byte
  assign wr_go     = (state_q == WRITE) && !((byte_addr[17:16] == IO_REGION) && full_q);
  assign rd_done   = (state_q == READ) && (k_q == n_q);
  assign cap_idx   = 2'(k_q - 3'd1);

  always_comb begin
    rd_word = buf_q;
    if (k_q != 3'd0) rd_word[{cap_idx, 3'b000} +: 8] = bus.mem_din_in;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (acc_lsb)     state_d = lsb_rw ? WRITE : READ;
               else if (acc_if) state_d = READ;
      READ:    if (rb || rd_done)   state_d = IDLE;
      WRITE:   if (wr_go && last_k) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_a_out    = '0;
    bus.mem_wr_out   = 1'b0;
    bus.mem_dout_out = 8'h00;
    if (state_q == READ && k_q < n_q) bus.mem_a_out = byte_addr;
    if (wr_go) begin
      bus.mem_a_out    = byte_addr;
      bus.mem_wr_out   = 1'b1;
      bus.mem_dout_out = wdata_q[{k_q[1:0], 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q <= '0; n_q <= '0; own_lsb_q <= 1'b0; full_q <= 1'b0;
      addr_q <= '0; wdata_q <= '0; buf_q <= '0;
      if_pend_q <= 1'b0; lsb_pend_q <= 1'b0; lsb_rw_pend_q <= 1'b0;
      if_addr_pend_q <= '0; lsb_addr_pend_q <= '0;
      lsb_goal_pend_q <= '0; lsb_data_pend_q <= '0;
      lsb_rdy_q <= 1'b0; if_rdy_q <= 1'b0; lsb_data_q <= '0; if_inst_q <= '0;
    end else begin
      lsb_rdy_q <= 1'b0;
      if_rdy_q  <= 1'b0;
      full_q    <= bus.io_buffer_full_in;

      if (acc_lsb || (rb && !lsb_rw_pend_q)) lsb_pend_q <= 1'b0;
      if (lsb_new && !acc_lsb) begin
        lsb_pend_q      <= 1'b1;
        lsb_rw_pend_q   <= bus.lsb_rw_signal_in;
        lsb_addr_pend_q <= bus.lsb_address_in;
        lsb_goal_pend_q <= bus.lsb_goal_in;
        lsb_data_pend_q <= bus.lsb_data_in;
      end
      if (acc_if || rb) if_pend_q <= 1'b0;
      if (if_new && !acc_if) begin
        if_pend_q      <= 1'b1;
        if_addr_pend_q <= bus.if_address_in;
      end

      if (acc_lsb || acc_if) begin
        k_q       <= '0;
        buf_q     <= '0;
        own_lsb_q <= acc_lsb;
        addr_q    <= acc_lsb ? lsb_addr : if_addr;
        n_q       <= acc_lsb ? goal_n(lsb_goal) : 3'd4;
        wdata_q   <= lsb_data;
      end

      if (state_q == READ && !rb) begin
        buf_q <= rd_word;
        if (rd_done) begin
          if (own_lsb_q) begin lsb_rdy_q <= 1'b1; lsb_data_q <= rd_word; end
          else           begin if_rdy_q  <= 1'b1; if_inst_q  <= rd_word; end
        end else begin
          k_q <= k_q + 3'd1;
        end
      end

      if (wr_go) begin
        k_q <= k_q + 3'd1;
        if (last_k) lsb_rdy_q <= 1'b1;
      end
    end
  end

  assign bus.lsb_ready_out = lsb_rdy_q;
  assign bus.lsb_data_out  = lsb_data_q;
  assign bus.if_ready_out  = if_rdy_q;
  assign bus.if_inst_out   = if_inst_q;
endmodule

// File: tb/tb_memory_controller.sv
// Bench for memory_controller: byte-addressed RAM model plus a per-cycle
// expectation table built from the transfer timing rules.
module tb_memory_controller;
  localparam int NC = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  memory_controller_if bus ();
  memory_controller dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  logic [7:0]  ram     [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  logic [31:0] last_ld = 32'h0;

  logic [31:0] exp_a  [NC];
  logic [7:0]  exp_do [NC];
  logic [31:0] exp_ld [NC];
  logic [31:0] exp_id [NC];
  bit chk_a [NC], exp_wr [NC], exp_lr [NC], exp_ir [NC], full_v [NC], rb_v [NC];

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
  endfunction
  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : dflt(a);
  endfunction
  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction
  function automatic int nbytes(input logic [2:0] g);
    return (g == 3'd1) ? 1 : (g == 3'd2) ? 2 : 4;
  endfunction

  // RAM: write on mem_wr, read byte appears the cycle after its address
  always @(posedge clk) begin
    if (bus.mem_wr_out) ram[bus.mem_a_out] = bus.mem_dout_out;
    bus.mem_din_in <= ram_rd(bus.mem_a_out);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [31:0] a, input logic [7:0] b);
    ram[a] = b;
    ref_mem[a] = b;
  endtask

  task automatic clear_exp();
    for (int c = 0; c < NC; c++) begin
      exp_a[c] = '0; chk_a[c] = 1'b1; exp_do[c] = '0; exp_ld[c] = '0; exp_id[c] = '0;
      exp_wr[c] = 1'b0; exp_lr[c] = 1'b0; exp_ir[c] = 1'b0; full_v[c] = 1'b0; rb_v[c] = 1'b0;
    end
  endtask

  // Read accepted at cycle t: byte k addressed in t+1+k, ready in t+n+2
  task automatic add_read(input int t, input logic [31:0] a, input int n, input bit lsb,
                          output int rdy);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < n; k++) begin
      exp_a[t+1+k] = a + 32'(k);
      w = w | (32'(ref_rd(a + 32'(k))) << (8 * k));
    end
    chk_a[t+n+1] = 1'b0;
    rdy = t + n + 2;
    if (lsb) begin exp_lr[rdy] = 1'b1; exp_ld[rdy] = w; last_ld = w; end
    else     begin exp_ir[rdy] = 1'b1; exp_id[rdy] = w; end
  endtask

  // Write accepted at cycle t: one byte per cycle unless IO and full the cycle before
  task automatic add_write(input int t, input logic [31:0] a, input int n, input logic [31:0] d,
                           output int rdy);
    int k, c;
    bit io;
    k = 0; c = t + 1;
    io = (a[17:16] == 2'b11);
    while (k < n && c < NC - 2) begin
      if (io && full_v[c-1]) chk_a[c] = 1'b0;
      else begin
        exp_wr[c] = 1'b1;
        exp_a[c]  = a + 32'(k);
        exp_do[c] = d[8*k +: 8];
        ref_mem[a + 32'(k)] = d[8*k +: 8];
        k++;
      end
      c++;
    end
    rdy = c;
    exp_lr[c] = 1'b1;
    exp_ld[c] = last_ld;
  endtask

  task automatic lsb_req(input bit rw, input logic [31:0] a, input logic [2:0] g,
                         input logic [31:0] d);
    bus.lsb_request_in = 1'b1; bus.lsb_rw_signal_in = rw;
    bus.lsb_address_in = a; bus.lsb_goal_in = g; bus.lsb_data_in = d;
  endtask

  task automatic if_req(input logic [31:0] a);
    bus.if_request_in = 1'b1; bus.if_address_in = a;
  endtask

  // Cycle 0 is the current cycle (request pulses already driven)
  task automatic run(input int ncyc);
    bus.io_buffer_full_in = full_v[0];
    bus.rob_rollback_in   = rb_v[0];
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      bus.lsb_request_in = 1'b0;
      bus.if_request_in  = 1'b0;
      bus.io_buffer_full_in = full_v[c];
      bus.rob_rollback_in   = rb_v[c];
      chk($sformatf("mem_wr@%0d", c), 32'(bus.mem_wr_out), 32'(exp_wr[c]));
      if (chk_a[c])  chk($sformatf("mem_a@%0d", c), bus.mem_a_out, exp_a[c]);
      if (exp_wr[c]) chk($sformatf("mem_dout@%0d", c), 32'(bus.mem_dout_out), 32'(exp_do[c]));
      chk($sformatf("lsb_ready@%0d", c), 32'(bus.lsb_ready_out), 32'(exp_lr[c]));
      chk($sformatf("if_ready@%0d", c), 32'(bus.if_ready_out), 32'(exp_ir[c]));
      if (exp_lr[c]) chk($sformatf("lsb_data@%0d", c), bus.lsb_data_out, exp_ld[c]);
      if (exp_ir[c]) chk($sformatf("if_inst@%0d", c), bus.if_inst_out, exp_id[c]);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int r, r2, kind;
    logic [31:0] a, d, sv;
    logic [2:0] g;

    rst = 1'b1;
    bus.if_request_in = 1'b0; bus.if_address_in = '0;
    bus.lsb_request_in = 1'b0; bus.lsb_rw_signal_in = 1'b0; bus.lsb_address_in = '0;
    bus.lsb_goal_in = '0; bus.lsb_data_in = '0;
    bus.rob_rollback_in = 1'b0; bus.io_buffer_full_in = 1'b0;
    clear_exp();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_a", bus.mem_a_out, 32'h0);
    chk("rst_mem_wr", 32'(bus.mem_wr_out), 32'h0);
    chk("rst_mem_dout", 32'(bus.mem_dout_out), 32'h0);
    chk("rst_lsb_ready", 32'(bus.lsb_ready_out), 32'h0);
    chk("rst_if_ready", 32'(bus.if_ready_out), 32'h0);
    chk("rst_lsb_data", bus.lsb_data_out, 32'h0);
    chk("rst_if_inst", bus.if_inst_out, 32'h0);
    rst = 1'b0;

    // LW at 0x100
    clear_exp();
    put(32'h100, 8'h78); put(32'h101, 8'h56); put(32'h102, 8'h34); put(32'h103, 8'h12);
    lsb_req(1'b0, 32'h100, 3'd4, 32'h0);
    add_read(0, 32'h100, 4, 1'b1, r);
    exp_ld[6] = 32'h12345678;
    run(r + 1);

    // SH at 0x200, no trailing writes
    clear_exp();
    lsb_req(1'b1, 32'h200, 3'd2, 32'hAABBCCDD);
    add_write(0, 32'h200, 2, 32'hAABBCCDD, r);
    run(r + 3);

    // Simultaneous IF + LSB: LSB first, IF accepted on the LSB ready cycle
    clear_exp();
    put(32'h500, 8'h13); put(32'h501, 8'h00); put(32'h502, 8'h00); put(32'h503, 8'h00);
    lsb_req(1'b0, 32'h400, 3'd4, 32'h0);
    if_req(32'h500);
    add_read(0, 32'h400, 4, 1'b1, r);
    add_read(r, 32'h500, 4, 1'b0, r2);
    exp_id[12] = 32'h00000013;
    run(r2 + 1);

    // IO store stalled by a full buffer for 3 cycles
    clear_exp();
    full_v[0] = 1'b1; full_v[1] = 1'b1; full_v[2] = 1'b1;
    lsb_req(1'b1, 32'h30000, 3'd1, 32'h41);
    add_write(0, 32'h30000, 1, 32'h41, r);
    run(r + 2);

    // Rollback after byte 2 captured, IF pending: nothing completes
    clear_exp();
    sv = last_ld;
    lsb_req(1'b0, 32'h600, 3'd4, 32'h0);
    if_req(32'h700);
    add_read(0, 32'h600, 4, 1'b1, r);
    last_ld = sv;
    rb_v[5] = 1'b1;
    for (int c = 5; c < NC; c++) begin exp_lr[c] = 1'b0; exp_ld[c] = '0; end
    for (int c = 6; c < NC; c++) begin chk_a[c] = 1'b1; exp_a[c] = '0; end
    run(14);

    clear_exp();
    lsb_req(1'b0, 32'h600, 3'd4, 32'h0);
    add_read(0, 32'h600, 4, 1'b1, r);
    run(r + 1);

    // Pulses coincident with rollback are dropped
    clear_exp();
    rb_v[0] = 1'b1;
    lsb_req(1'b0, 32'h640, 3'd4, 32'h0);
    if_req(32'h680);
    run(9);

    // LB zero-extension
    clear_exp();
    put(32'h800, 8'hF0);
    lsb_req(1'b0, 32'h800, 3'd1, 32'h0);
    add_read(0, 32'h800, 1, 1'b1, r);
    exp_ld[r] = 32'h000000F0;
    run(r + 1);

    // Rollback during a committed store does not shorten it
    clear_exp();
    rb_v[2] = 1'b1;
    lsb_req(1'b1, 32'h900, 3'd4, 32'h11223344);
    add_write(0, 32'h900, 4, 32'h11223344, r);
    run(r + 2);

    // Read back the store, and a load wrapping the 32-bit address space
    clear_exp();
    lsb_req(1'b0, 32'h900, 3'd4, 32'h0);
    add_read(0, 32'h900, 4, 1'b1, r);
    exp_ld[r] = 32'h11223344;
    run(r + 1);
    clear_exp();
    lsb_req(1'b0, 32'hFFFF_FFFE, 3'd4, 32'h0);
    add_read(0, 32'hFFFF_FFFE, 4, 1'b1, r);
    run(r + 1);

    // Random loads, stores and fetches against the byte-array model
    for (int i = 0; i < 30; i++) begin
      clear_exp();
      for (int c = 0; c < 20; c++) full_v[c] = ($urandom_range(0, 3) == 0);
      kind = $urandom_range(0, 2);
      a = $urandom;
      d = $urandom;
      g = 3'($urandom_range(0, 7));
      if (kind == 0) begin
        lsb_req(1'b0, a, g, 32'h0);
        add_read(0, a, nbytes(g), 1'b1, r);
      end else if (kind == 1) begin
        a[15:0] = 16'($urandom_range(0, 16'hFFF0));
        if ($urandom_range(0, 1) == 1) a[17:16] = 2'b11;
        lsb_req(1'b1, a, g, d);
        add_write(0, a, nbytes(g), d, r);
      end else begin
        if_req(a);
        add_read(0, a, 4, 1'b0, r);
      end
      run(r + 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
